// File: rtl/memory_bank_pkg.sv
// Shared types and helpers for the memory bank: FSM state encoding and
// sweep-index sizing.
package memory_bank_pkg;

  // Bank operating state: normal access or zeroing sweep in progress.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // Bit width needed to count 0..n-1, never less than one bit so that a
  // counter register always exists.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Sweep index width for the default bank depth; instances size their own
  // index from their DEPTH with clog2_min1.
  localparam int DEFAULT_DEPTH = 4;
  localparam int SWEEP_IDX_W   = clog2_min1(DEFAULT_DEPTH);

endpackage

// File: rtl/memory_word.sv
// One storage word: a WIDTH-bit enabled register plus a "written" flag.
// Reset clears only the flag; the data register keeps its contents.
module memory_word
  import memory_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             zero,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] word,
  output logic             flag
);

  logic [WIDTH-1:0] word_reg;
  logic             flag_reg;

  // Data register: sweep zeroing wins over a write; not affected by reset.
  always_ff @(posedge clk) begin
    if (zero) begin
      word_reg <= '0;
    end else if (we) begin
      word_reg <= wdata;
    end
  end

  // Written flag: set by a write, cleared by reset or by the sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_reg <= 1'b0;
    end else if (zero) begin
      flag_reg <= 1'b0;
    end else if (we) begin
      flag_reg <= 1'b1;
    end
  end

  assign word = word_reg;
  assign flag = flag_reg;

endmodule

// File: rtl/memory_bank.sv
// DEPTH x WIDTH memory bank with synchronous write, registered read,
// per-word written flags and a multi-cycle clear sweep.
module memory_bank
  import memory_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    addr,
  input  logic             store,
  input  logic             load,
  input  logic             clear,
  output logic [WIDTH-1:0] memory,
  output logic             mem_valid,
  output logic             hit,
  output logic             busy,
  output logic             reject
);

  localparam int IW = clog2_min1(DEPTH);

  state_t           state_reg, state_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [WIDTH-1:0] memory_reg;
  logic             mem_valid_reg, hit_reg, reject_reg;

  logic [WIDTH-1:0] word_q [DEPTH];
  logic [DEPTH-1:0] flag_q;
  logic [WIDTH-1:0] rd_word;
  logic             rd_flag;
  logic             sweeping, addr_ok, store_ok, load_ok, reject_next, last_idx;

  // Request qualification and next-state logic for the sweep FSM.
  always_comb begin
    sweeping    = (state_reg == SWEEP);
    addr_ok     = (int'(addr) < DEPTH);
    store_ok    = store && !sweeping && !clear && addr_ok;
    load_ok     = load && !sweeping && !clear && addr_ok;
    // One pulse per cycle, whether one or both requests were dropped.
    reject_next = (store || load) && (sweeping || clear || !addr_ok);
    last_idx    = (idx_reg == IW'(DEPTH - 1));
    state_next  = state_reg;
    idx_next    = idx_reg;
    if (sweeping) begin
      if (last_idx) begin
        state_next = IDLE;
        idx_next   = '0;
      end else begin
        idx_next = idx_reg + 1'b1;
      end
    end else if (clear) begin
      state_next = SWEEP;
      idx_next   = '0;
    end
  end

  // Word storage; reset suppresses both writes and sweep zeroing that cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      memory_word #(.WIDTH(WIDTH)) u_word (
        .clk   (clk),
        .reset (reset),
        .we    (store_ok && (addr == AW'(gi)) && !reset),
        .zero  (sweeping && (idx_reg == IW'(gi)) && !reset),
        .wdata (data),
        .word  (word_q[gi]),
        .flag  (flag_q[gi])
      );
    end
  endgenerate

  // Read mux: selects the pre-edge word/flag, giving read-before-write.
  always_comb begin
    rd_word = '0;
    rd_flag = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == AW'(i)) begin
        rd_word = word_q[i];
        rd_flag = flag_q[i];
      end
    end
  end

  // FSM state and sweep index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Registered read port and status pulses; memory holds between loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      memory_reg    <= '0;
      mem_valid_reg <= 1'b0;
      hit_reg       <= 1'b0;
      reject_reg    <= 1'b0;
    end else begin
      mem_valid_reg <= load_ok;
      reject_reg    <= reject_next;
      if (load_ok) begin
        memory_reg <= rd_word;
        hit_reg    <= rd_flag;
      end
    end
  end

  assign memory    = memory_reg;
  assign mem_valid = mem_valid_reg;
  assign hit       = hit_reg;
  assign reject    = reject_reg;
  assign busy      = sweeping;

endmodule

// File: tb/tb_memory_bank.sv
// Self-checking bench: two banks (DEPTH=4 and DEPTH=3) share one stimulus
// stream and are compared every cycle against a behavioural model, with
// directed scenarios pinned by literal expectations followed by random traffic.
module tb_memory_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1, store = 1'b0, load = 1'b0, clear = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] addr = 2'd0;

  logic [7:0] mem4, mem3;
  logic       valid4, hit4, busy4, rej4;
  logic       valid3, hit3, busy3, rej3;

  int checks = 0;
  int failures = 0;
  bit verbose = 1'b1;

  always #5 clk = ~clk;

  memory_bank #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .data(data), .addr(addr), .store(store),
    .load(load), .clear(clear), .memory(mem4), .mem_valid(valid4),
    .hit(hit4), .busy(busy4), .reject(rej4)
  );

  memory_bank #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .data(data), .addr(addr), .store(store),
    .load(load), .clear(clear), .memory(mem3), .mem_valid(valid3),
    .hit(hit3), .busy(busy3), .reject(rej3)
  );

  // ---------------- behavioural model (index 0: DEPTH=4, 1: DEPTH=3)
  logic [7:0] m_word  [2][4];
  bit         m_known [2][4];
  bit         m_flag  [2][4];
  int         m_left  [2];
  int         m_pos   [2];
  logic [7:0] e_mem   [2];
  bit e_mem_known[2], e_valid[2], e_hit[2], e_hit_chk[2], e_rej[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) begin
        m_word[k][j] = 8'h00; m_known[k][j] = 0; m_flag[k][j] = 0;
      end
      m_left[k] = 0; m_pos[k] = 0; e_mem[k] = 8'h00;
      e_mem_known[k] = 0; e_valid[k] = 0; e_hit[k] = 0; e_hit_chk[k] = 0; e_rej[k] = 0;
    end
  end

  function automatic int dep(int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at it.
  task automatic step(int k);
    int  d;
    bit  ok;
    int  a;
    d = dep(k);
    a = int'(addr);
    if (reset) begin
      e_mem[k] = 8'h00; e_mem_known[k] = 1; e_valid[k] = 0;
      e_hit[k] = 0; e_hit_chk[k] = 1; e_rej[k] = 0;
      for (int j = 0; j < 4; j++) m_flag[k][j] = 0;
      m_left[k] = 0; m_pos[k] = 0;
    end else begin
      e_valid[k] = 0; e_hit_chk[k] = 0;
      if (m_left[k] > 0) begin
        m_word[k][m_pos[k]] = 8'h00; m_known[k][m_pos[k]] = 1;
        m_flag[k][m_pos[k]] = 0;
        m_pos[k]++; m_left[k]--;
        e_rej[k] = store || load;
      end else if (clear) begin
        e_rej[k] = store || load;
        m_left[k] = d; m_pos[k] = 0;
      end else begin
        ok = (a < d);
        e_rej[k] = (store || load) && !ok;
        if (load && ok) begin
          e_mem[k] = m_word[k][a]; e_mem_known[k] = m_known[k][a];
          e_hit[k] = m_flag[k][a]; e_valid[k] = 1; e_hit_chk[k] = 1;
        end
        if (store && ok) begin
          m_word[k][a] = data; m_known[k][a] = 1; m_flag[k][a] = 1;
        end
      end
    end
  endtask

  task automatic cmp(int k, logic [7:0] mem, logic v, logic h, logic b, logic r);
    string p;
    p = (k == 0) ? "d4" : "d3";
    chk({p, ".mem_valid"}, v, e_valid[k]);
    chk({p, ".reject"}, r, e_rej[k]);
    chk({p, ".busy"}, b, m_left[k] > 0);
    if (e_hit_chk[k]) chk({p, ".hit"}, h, e_hit[k]);
    if (e_mem_known[k]) chk({p, ".memory"}, mem, e_mem[k]);
  endtask

  // Single compare process: model at the edge, DUT sampled 1 time unit later.
  always @(posedge clk) begin
    step(0);
    step(1);
    #1;
    cmp(0, mem4, valid4, hit4, busy4, rej4);
    cmp(1, mem3, valid3, hit3, busy3, rej3);
  end

  // ---------------- stimulus
  task automatic cyc(bit r, bit s, bit l, bit c, logic [1:0] a, logic [7:0] d);
    reset = r; store = s; load = l; clear = c; addr = a; data = d;
    @(posedge clk);
    #2;
    if (verbose)
      $display("tx r=%0b st=%0b ld=%0b clr=%0b a=%0d d=%02h | d4 mem=%02h v=%0b h=%0b b=%0b rj=%0b | d3 mem=%02h v=%0b h=%0b b=%0b rj=%0b",
               r, s, l, c, a, d, mem4, valid4, hit4, busy4, rej4,
               mem3, valid3, hit3, busy3, rej3);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 2'd0, 8'h00);
  endtask

  initial begin
    int cnt;
    logic [7:0] held;

    // 1: reset state, store then load
    cyc(1, 0, 0, 0, 2'd0, 8'h00);
    chk("rst.memory", mem4, 8'h00);
    chk("rst.mem_valid", valid4, 1'b0);
    chk("rst.busy", busy4, 1'b0);
    chk("rst.reject", rej4, 1'b0);
    cyc(0, 1, 0, 0, 2'd2, 8'hA5);
    cyc(0, 0, 1, 0, 2'd2, 8'h00);
    chk("t1.memory", mem4, 8'hA5);
    chk("t1.hit", hit4, 1'b1);
    chk("t1.valid", valid4, 1'b1);
    idle();
    chk("t1.valid_pulse", valid4, 1'b0);
    chk("t1.memory_hold", mem4, 8'hA5);

    // 2: unwritten load, read-before-write, then fresh read
    cyc(0, 0, 1, 0, 2'd1, 8'h00);
    chk("t2.valid", valid4, 1'b1);
    chk("t2.hit_unwritten", hit4, 1'b0);
    cyc(0, 1, 1, 0, 2'd1, 8'h3C);
    chk("t2.rbw_hit", hit4, 1'b0);
    cyc(0, 0, 1, 0, 2'd1, 8'h00);
    chk("t2.memory", mem4, 8'h3C);
    chk("t2.hit", hit4, 1'b1);

    // 3: fill, clear, second clear and store mid-sweep
    cyc(0, 1, 0, 0, 2'd0, 8'h11);
    cyc(0, 1, 0, 0, 2'd1, 8'h22);
    cyc(0, 1, 0, 0, 2'd2, 8'h33);
    cyc(0, 1, 0, 0, 2'd3, 8'h44);
    cyc(0, 0, 0, 1, 2'd0, 8'h00);
    cnt = 0;
    while (busy4 && cnt < 20) begin
      cnt++;
      if (cnt == 1) begin
        cyc(0, 0, 0, 1, 2'd0, 8'h00);
        chk("t3.clear_no_reject", rej4, 1'b0);
      end else if (cnt == 2) begin
        cyc(0, 1, 0, 0, 2'd0, 8'hFF);
        chk("t3.store_reject", rej4, 1'b1);
      end else begin
        idle();
      end
    end
    chk("t3.busy_cycles", cnt, 4);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 2'(i), 8'h00);
      chk("t3.zero_mem", mem4, 8'h00);
      chk("t3.zero_hit", hit4, 1'b0);
    end

    // 4: reset in the second sweep cycle
    cyc(0, 1, 0, 0, 2'd1, 8'h55);
    cyc(0, 0, 0, 1, 2'd0, 8'h00);
    idle();
    cyc(1, 1, 1, 0, 2'd2, 8'hEE);
    chk("t4.busy", busy4, 1'b0);
    chk("t4.reject", rej4, 1'b0);
    chk("t4.valid", valid4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 2'(i), 8'h00);
      chk("t4.hit_cleared", hit4, 1'b0);
    end
    cyc(0, 1, 0, 0, 2'd3, 8'h5A);
    cyc(0, 0, 1, 0, 2'd3, 8'h00);
    chk("t4.memory", mem4, 8'h5A);
    chk("t4.hit", hit4, 1'b1);

    // 5: out-of-range address on the DEPTH=3 bank
    cyc(0, 1, 0, 0, 2'd2, 8'h66);
    cyc(0, 0, 1, 0, 2'd2, 8'h00);
    chk("t5.d3_mem", mem3, 8'h66);
    held = mem3;
    cyc(0, 1, 0, 0, 2'd3, 8'h11);
    chk("t5.store_reject", rej3, 1'b1);
    cyc(0, 0, 1, 0, 2'd3, 8'h00);
    chk("t5.load_reject", rej3, 1'b1);
    chk("t5.valid", valid3, 1'b0);
    chk("t5.mem_hold", mem3, held);
    cyc(0, 0, 1, 0, 2'd2, 8'h00);
    chk("t5.word_kept", mem3, 8'h66);

    // 6: clear together with a store in IDLE
    cyc(0, 1, 0, 1, 2'd0, 8'h77);
    chk("t6.reject", rej4, 1'b1);
    cnt = 0;
    while (busy4 && cnt < 20) begin
      cnt++;
      idle();
    end
    chk("t6.sweep_done", busy4, 1'b0);
    cyc(0, 0, 1, 0, 2'd0, 8'h00);
    chk("t6.memory", mem4, 8'h00);
    chk("t6.hit", hit4, 1'b0);

    // Random traffic, checked by the model every cycle.
    verbose = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      cyc(r < 2, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 45,
          (r >= 2 && r < 6), 2'($urandom_range(0, 3)), 8'($urandom));
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
